// File: rtl/mmu_pkg.sv
// mmu_pkg: FSM state encoding and array defaults shared by the MMU sequencer.
package mmu_pkg;
    localparam int MMU_ROWS    = 4;
    localparam int MMU_COLS    = 4;
    localparam int PE_PROD_LAT = 1;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE} mmu_state_e;
endpackage

// File: rtl/mmu_skew_line.sv
// mmu_skew_line: DEPTH-stage 1-bit delay line with synchronous clear.
module mmu_skew_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);
    logic [DEPTH-1:0] sr_q, sr_d;
    always_comb sr_d = clr_i ? '0 : (sr_q << 1) | DEPTH'(d_i);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sr_q <= '0;
        else        sr_q <= sr_d;
    end
    assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/mmu_seq_ctrl.sv
// mmu_seq_ctrl: job sequencer for the weight-stationary systolic MMU.
// Define MMU_SEQ_CTRL_PERF_CNT_EN to add the perf_cycles_o job cycle counter.
module mmu_seq_ctrl
    import mmu_pkg::*;
#(
    parameter int ARRAY_ROWS = MMU_ROWS,
    parameter int ARRAY_COLS = MMU_COLS,
    parameter int VEC_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [VEC_W-1:0]              num_vecs_i,
    input  logic                          abort_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          weight_en_o,
    output logic [$clog2(ARRAY_ROWS)-1:0] weight_rd_addr_o,
    output logic                          ifmap_rd_en_o,
    output logic [VEC_W-1:0]              ifmap_rd_addr_o,
    output logic [ARRAY_ROWS-1:0]         ifmap_en_o,
    output logic [ARRAY_COLS-1:0]         psum_en_o,
    output logic [ARRAY_COLS-1:0]         ofmap_valid_o
`ifdef MMU_SEQ_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]                   perf_cycles_o
`endif
);
    localparam int AW = $clog2(ARRAY_ROWS);
    localparam int CW = $clog2(ARRAY_ROWS + ARRAY_COLS);
    localparam logic [AW-1:0] W_LAST = AW'(ARRAY_ROWS - 1);
    localparam logic [CW-1:0] D_LAST = CW'(ARRAY_ROWS + ARRAY_COLS - 1);

    mmu_state_e       state_q;
    logic [VEC_W-1:0] n_q, raddr_q;
    logic [AW-1:0]    waddr_q;
    logic [CW-1:0]    cnt_q;
    logic             weight_en_q, rd_en_q, done_q, clr;

    assign busy_o           = state_q != S_IDLE;
    assign clr              = abort_i & busy_o;
    assign done_o           = done_q;
    assign weight_en_o      = weight_en_q;
    assign weight_rd_addr_o = waddr_q;
    assign ifmap_rd_en_o    = rd_en_q;
    assign ifmap_rd_addr_o  = raddr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr) begin
            state_q     <= S_IDLE;
            n_q         <= '0;
            waddr_q     <= '0;
            raddr_q     <= '0;
            cnt_q       <= '0;
            weight_en_q <= 1'b0;
            rd_en_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start_i) begin
                    state_q     <= S_LOAD_W;
                    n_q         <= num_vecs_i;
                    waddr_q     <= '0;
                    raddr_q     <= '0;
                    weight_en_q <= 1'b1;
                end
                S_LOAD_W: if (waddr_q == W_LAST) begin
                    weight_en_q <= 1'b0;
                    cnt_q       <= '0;
                    rd_en_q     <= n_q != '0;
                    state_q     <= (n_q == '0) ? S_DRAIN : S_STREAM;
                end else begin
                    waddr_q <= waddr_q + AW'(1);
                end
                S_STREAM: if (raddr_q == n_q - VEC_W'(1)) begin
                    rd_en_q <= 1'b0;
                    state_q <= S_DRAIN;
                end else begin
                    raddr_q <= raddr_q + VEC_W'(1);
                end
                S_DRAIN: if (cnt_q == D_LAST) begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Every skewed enable/valid is a delayed copy of the ifmap read strobe.
    for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_row
        if (r == 0) begin : g_d0
            assign ifmap_en_o[r] = rd_en_q;
        end else begin : g_dl
            mmu_skew_line #(.DEPTH(r)) u_line (
                .clk(clk), .rst_n(rst_n), .clr_i(clr), .d_i(rd_en_q), .q_o(ifmap_en_o[r])
            );
        end
    end

    for (genvar c = 0; c < ARRAY_COLS; c++) begin : g_col
        if (c == 0) begin : g_d0
            assign psum_en_o[c] = rd_en_q;
        end else begin : g_dl
            mmu_skew_line #(.DEPTH(c)) u_line (
                .clk(clk), .rst_n(rst_n), .clr_i(clr), .d_i(rd_en_q), .q_o(psum_en_o[c])
            );
        end
        mmu_skew_line #(.DEPTH(c + ARRAY_ROWS + PE_PROD_LAT)) u_ofm (
            .clk(clk), .rst_n(rst_n), .clr_i(clr), .d_i(rd_en_q), .q_o(ofmap_valid_o[c])
        );
    end

`ifdef MMU_SEQ_CTRL_PERF_CNT_EN
    logic [31:0] perf_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        perf_q <= '0;
        else if (clr || (!busy_o && start_i)) perf_q <= '0;
        else if (busy_o && perf_q != '1)   perf_q <= perf_q + 32'd1;
    end
    assign perf_cycles_o = perf_q;
`endif
endmodule
